// File: rtl/alu_pipe_stream.sv
// rtl/alu_pipe_stream.sv - two-stage valid/ready ALU pipeline with sideband tag; optional shifter under ALU_PIPE_SHIFT_EN
module alu_pipe_stream #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_load;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

`ifdef ALU_PIPE_SHIFT_EN
    localparam int SH_W = $clog2(WIDTH);
    logic [SH_W-1:0]    sh;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [2*WIDTH-1:0] rol_ext;
`endif

    // An empty output register always accepts, so bubbles collapse.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Stage 1: capture the operation when the handshake completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= opcode;
                s1_a   <= A;
                s1_b   <= B;
                s1_tag <= in_tag;
            end
        end
    end

    // Compute result and carry/overflow from the stage-1 operation.
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
`ifdef ALU_PIPE_SHIFT_EN
        sh      = s1_b[SH_W-1:0];
        shl_ext = '0;
        shr_ext = '0;
        rol_ext = '0;
`endif
        case (s1_op)
            4'b0000: begin
                sum_ext = {1'b0, s1_a} + {1'b0, s1_b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (s1_a[MSB] == s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
            end
            4'b0001: begin
                // Bit WIDTH of the extended difference is the borrow (A < B).
                sum_ext = {1'b0, s1_a} - {1'b0, s1_b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (s1_a[MSB] != s1_b[MSB]) && (alu_res[MSB] != s1_a[MSB]);
            end
            4'b0010: alu_res = s1_a & s1_b;
            4'b0011: alu_res = s1_a | s1_b;
            4'b0100: alu_res = s1_a ^ s1_b;
            4'b0101: alu_res = ~s1_a;
            4'b0110: alu_res = s1_b;
`ifdef ALU_PIPE_SHIFT_EN
            4'b0111: begin
                shl_ext = {1'b0, s1_a} << sh;
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            4'b1000: begin
                shr_ext = {s1_a, 1'b0} >> sh;
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            4'b1001: begin
                shr_ext = $unsigned($signed({s1_a, 1'b0}) >>> sh);
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            4'b1010: begin
                rol_ext = {s1_a, s1_a} << sh;
                alu_res = rol_ext[2*WIDTH-1:WIDTH];
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            out_tag   <= '0;
            illegal   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= alu_res;
                flags   <= {alu_c, alu_v, alu_res[MSB], (alu_res == '0)};
                out_tag <= s1_tag;
                illegal <= alu_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_stream.sv
// tb/tb_alu_pipe_stream.sv - self-checking bench for alu_pipe_stream
`timescale 1ns/1ps
module tb_alu_pipe_stream;

    localparam int W = 8;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   opcode = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [T-1:0] in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [T-1:0] out_tag;
    logic [3:0]   flags;
    logic         illegal;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    logic [W+4:0] exp_q[$];
    logic [T-1:0] tag_q[$];
    logic [W+4:0] e_val;
    logic         h_act = 1'b0;
    logic [W+4:0] h_val;
    logic [T-1:0] h_tag;

    alu_pipe_stream #(.WIDTH(W), .TAG_W(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .A(A), .B(B), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .flags(flags), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {illegal, carry, overflow, negative, zero, result} from plain integer arithmetic.
    function automatic logic [W+4:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, sa, sb, r, sr, n;
        logic c, v, ill;
        logic [W-1:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); n = ub % W;
        c = 1'b0; v = 1'b0; ill = 1'b0; r = 0; sr = 0;
        case (op)
            4'd0: begin r = ua + ub; sr = sa + sb; c = (r >= (1 << W));
                        v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1))); end
            4'd1: begin r = ua - ub; sr = sa - sb; c = (ua < ub);
                        v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1))); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ~ua;
            4'd6: r = ub;
`ifdef ALU_PIPE_SHIFT_EN
            4'd7:  begin r = ua << n; c = ((r >> W) & 1) != 0; end
            4'd8:  begin r = ua >> n; c = (n != 0) && (((ua >> (n-1)) & 1) != 0); end
            4'd9:  begin r = sa >>> n; c = (n != 0) && (((ua >> (n-1)) & 1) != 0); end
            4'd10: r = (ua << n) | (ua >> (W - n));
`endif
            default: ill = 1'b1;
        endcase
        res = ill ? '0 : r[W-1:0];
        return {ill, c, v, res[W-1], (res == '0), res};
    endfunction

    // Scoreboard: predict on input handshake, compare on output handshake, check stalls hold.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            tag_q.delete();
            h_act = 1'b0;
        end else begin
            if (h_act) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {illegal, flags, result}, h_val);
                chk("hold_tag", out_tag, h_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_with_empty_queue", out_valid, 0);
                end else begin
                    e_val = exp_q.pop_front();
                    chk("out_data", {illegal, flags, result}, e_val);
                    chk("out_tag", out_tag, tag_q.pop_front());
                    n_out++;
                end
            end
            h_act = out_valid && !out_ready;
            h_val = {illegal, flags, result};
            h_tag = out_tag;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(opcode, A, B));
                tag_q.push_back(in_tag);
            end
        end
    end

    // Present one operation (caller is just after a rising edge) and hold it until accepted.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [T-1:0] tag, output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1; opcode = op; A = a; B = b; in_tag = tag;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            waited++;
        end
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    // Single operation into an idle pipeline with literal expectations and latency check.
    task automatic single(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [T-1:0] tag, input logic [W-1:0] er,
                          input logic [3:0] ef, input logic ei);
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = op; A = a; B = b; in_tag = tag;
        @(negedge clk);
        chk({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_not_early"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_result"}, result, er);
        chk({name, "_flags"}, flags, ef);
        chk({name, "_tag"}, out_tag, tag);
        chk({name, "_illegal"}, illegal, ei);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, cyc, n0;
        logic [W-1:0] av, bv;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        chk("model_sub_3_5", model(4'd1, 8'h03, 8'h05), {1'b0, 4'b1010, 8'hFE});
        chk("model_add_7f_1", model(4'd0, 8'h7F, 8'h01), {1'b0, 4'b0110, 8'h80});

        single("add_5_3",   4'd0,  8'h05, 8'h03, 4'd1, 8'h08, 4'b0000, 1'b0);
        single("sub_3_5",   4'd1,  8'h03, 8'h05, 4'd2, 8'hFE, 4'b1010, 1'b0);
        single("add_7f_1",  4'd0,  8'h7F, 8'h01, 4'd3, 8'h80, 4'b0110, 1'b0);
        single("add_ff_1",  4'd0,  8'hFF, 8'h01, 4'd4, 8'h00, 4'b1001, 1'b0);
        single("ill_f",     4'd15, 8'h09, 8'h09, 4'd5, 8'h00, 4'b0001, 1'b1);
        single("after_ill", 4'd0,  8'h10, 8'h22, 4'd6, 8'h32, 4'b0000, 1'b0);
        single("xor_aa_55", 4'd4,  8'hAA, 8'h55, 4'd7, 8'hFF, 4'b0010, 1'b0);
        single("not_ff",    4'd5,  8'hFF, 8'h00, 4'd8, 8'h00, 4'b0001, 1'b0);
`ifdef ALU_PIPE_SHIFT_EN
        single("shl_81_1",  4'd7,  8'h81, 8'h01, 4'd9, 8'h02, 4'b1000, 1'b0);
        single("sra_81_1",  4'd9,  8'h81, 8'h01, 4'd10, 8'hC0, 4'b1010, 1'b0);
        single("rol_81_1",  4'd10, 8'h81, 8'h01, 4'd11, 8'h03, 4'b0000, 1'b0);
`else
        single("shl_81_1",  4'd7,  8'h81, 8'h01, 4'd9, 8'h00, 4'b0001, 1'b1);
`endif

        // Full-rate stream through every opcode with the consumer always ready.
        @(posedge clk); #1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            av = W'(8'h3C + i * 8'h17);
            bv = W'(i * 5 + 1);
            send(4'(i), av, bv, 4'(i), w);
            cyc += w;
        end
        in_valid = 1'b0;
        chk("throughput_cycles", cyc, 16);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stream1_drained", exp_q.size(), 0);

        // Stream against a stalling consumer.
        n0 = n_out;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    av = W'(i * 8'h2B + 8'h71);
                    bv = W'(8'hF0 - i * 8'h0D);
                    send(4'(i % 11), av, bv, 4'(i), w);
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    out_ready = (k % 3) != 0;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("stream2_drained", exp_q.size(), 0);
        chk("stream2_count", n_out - n0, 20);

        // Backpressure: two accepts fill the pipe, third waits, order preserved.
        n0 = n_out;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(4'd0, 8'h01, 8'h01, 4'd1, w);
        send(4'd0, 8'h02, 8'h02, 4'd2, w);
        in_valid = 1'b1; opcode = 4'd0; A = 8'h03; B = 8'h03; in_tag = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_tag", out_tag, 1);
            chk("bp_result", result, 8'h02);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_count", n_out - n0, 3);

        // Reset with both stages full discards everything in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(4'd2, 8'hF0, 8'h3C, 4'd8, w);
        send(4'd3, 8'h0F, 8'h30, 4'd9, w);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_stale_after_rst", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
